// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx.
//   rx        : serial line, idle high, asynchronous to the receiver clock
//   data      : last good byte (LSB received first)
//   valid     : one-cycle pulse, data just updated
//   frame_err : one-cycle pulse, stop bit sampled low (data not updated)
//   busy      : receiver is inside a frame (any state but idle)
// master = the receiver itself, slave = line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output valid, output frame_err, output busy);
  modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an internal oversampling tick of CLKF/(BR*OVS) clocks.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : uart_rx_if.master (rx in; data/valid/frame_err/busy out)
// rx is brought through a 2-FF synchroniser; all decisions use the synchronised
// copy. Bits are sampled mid-bit; the FSM returns to idle at mid-stop so a start
// bit directly following a stop bit is still caught.
module uart_rx #(
  parameter int unsigned BR   = 0,
  parameter int unsigned CLKF = 0,
  parameter int unsigned OVS  = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.master bus
);

  localparam int unsigned BOVS     = BR * OVS;
  localparam int unsigned BOVS_NZ  = (BOVS == 0) ? 1 : BOVS;
  localparam int unsigned TDIV_RAW = CLKF / BOVS_NZ;
  localparam int unsigned TDIV     = (TDIV_RAW == 0) ? 1 : TDIV_RAW;
  localparam int unsigned TW       = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned SW       = (OVS > 2) ? $clog2(OVS) : 2;

  localparam logic [TW-1:0] T_LAST = TW'(TDIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);

  if (BR == 0) begin : g_bad_br
    $fatal(1, "uart_rx: BR must be non-zero");
  end
  if (CLKF == 0) begin : g_bad_clkf
    $fatal(1, "uart_rx: CLKF must be non-zero");
  end
  if (OVS < 4 || (OVS % 2) != 0) begin : g_bad_ovs
    $fatal(1, "uart_rx: OVS must be even and >= 4");
  end
  if (CLKF < BOVS || (CLKF % BOVS_NZ) != 0) begin : g_bad_div
    $fatal(1, "uart_rx: CLKF must be a non-zero multiple of BR*OVS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            sync1_q, sync2_q;
  logic            rx_s;
  logic [TW-1:0]   tcnt_q;
  logic [SW-1:0]   s_q;
  logic [2:0]      b_q;
  logic [7:0]      shreg_q;
  logic [7:0]      data_q;
  logic            valid_q, ferr_q, busy_q;
  logic            tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
  assign tick = (tcnt_q == T_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      s_q     <= '0;
      b_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      // Tick counter runs only inside a frame; idle holds it cleared.
      if (state_q == S_IDLE) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
        if (tick) begin
          s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick && s_q == S_MID) begin
            if (!rx_s) begin
              state_q <= S_DATA;
              s_q     <= '0;
              b_q     <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick && s_q == S_LAST) begin
            shreg_q[b_q] <= rx_s;
            if (b_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              b_q <= b_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (tick && s_q == S_LAST) begin
            if (rx_s) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A held-low line reports one error, then waits for the line to recover.
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule
